// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit: sizes, aligns and lane-steers one memory access per start
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_load,
  input  logic        start_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        go, illegal, misal;
  logic [1:0]  size_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] byte_sh, half_sh, load_val;

  // Decode of the incoming request; store wins when both starts are high.
  always_comb begin
    go      = start_store | start_load;
    size_in = funct3[1:0];
    illegal = start_store ? (funct3 >= 3'd3)
                          : (funct3 == 3'd3 || funct3 >= 3'd6);
    misal   = (size_in == 2'd1 && addr[0]) ||
              (size_in == 2'd2 && addr[1:0] != 2'b00);
    case (size_in)
      2'd0:    be_in = 4'b0001 << addr[1:0];
      2'd1:    be_in = addr[1] ? 4'b1100 : 4'b0011;
      default: be_in = 4'b1111;
    endcase
    case (size_in)
      2'd0:    wdata_in = {4{wdata[7:0]}};
      2'd1:    wdata_in = {2{wdata[15:0]}};
      default: wdata_in = wdata;
    endcase
  end

  always_comb begin
    byte_sh = mem_rdata >> {lane_q, 3'b000};
    half_sh = lane_q[1] ? (mem_rdata >> 16) : mem_rdata;
    case (size_q)
      2'd0:    load_val = uns_q ? {24'd0, byte_sh[7:0]}
                                : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'd1:    load_val = uns_q ? {16'd0, half_sh[15:0]}
                                : {{16{half_sh[15]}}, half_sh[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (illegal || misal) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            cnt_d   = 8'd0;
            store_d = start_store;
            size_d  = size_in;
            uns_d   = funct3[2];
            lane_d  = addr[1:0];
            addr_d  = {addr[31:2], 2'b00};
            be_d    = be_in;
            wdata_d = wdata_in;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = DONE;
          if (!store_q) rdata_d = load_val;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are decoded from the next state so they leave a flop.
    mem_req_d = (state_d == REQ);
    mem_we_d  = (state_d == REQ) && store_d;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE) || (state_d == ERR);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      store_q   <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      lane_q    <= 2'd0;
      addr_q    <= 32'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      store_q   <= store_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule
